// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit type, header field offsets and side-buffer defaults.
package minbd_pkg;

    localparam int MINBD_FLIT_W      = 64;
    localparam int SIDEBUF_DEPTH     = 4;
    localparam int SIDEBUF_STARVE_TH = 8;

    localparam int HDR_DST_LSB = 0;
    localparam int HDR_DST_W   = 8;
    localparam int HDR_SRC_LSB = 8;
    localparam int HDR_SRC_W   = 8;

    typedef logic [MINBD_FLIT_W-1:0] flit_t;

endpackage

// File: rtl/minbd_sidebuf_fifo.sv
// Side-buffer storage: first-word-fall-through FIFO with occupancy count.
module minbd_sidebuf_fifo
    import minbd_pkg::*;
#(
    parameter int FLIT_W = MINBD_FLIT_W,
    parameter int DEPTH  = SIDEBUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              grant,
    output logic              full,
    output logic              valid,
    output logic [FLIT_W-1:0] flit,
    output logic [CNT_W-1:0]  count
);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign valid = (count != '0);
    assign flit  = mem[rd_ptr];

    // Full is derived from count only, so a grant in the same cycle never frees room for the write.
    assign wr_en = in_valid & ~full;
    assign rd_en = grant & valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/minbd_side_buffer.sv
// MinBD side buffer: holds diverted flits for re-injection and requests redirection when starved.
module minbd_side_buffer
    import minbd_pkg::*;
#(
    parameter int FLIT_W    = MINBD_FLIT_W,
    parameter int DEPTH     = SIDEBUF_DEPTH,
    parameter int STARVE_TH = SIDEBUF_STARVE_TH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       buf_in_valid,
    input  logic [FLIT_W-1:0]          buf_in_flit,
    output logic                       buf_full,
    output logic                       out_valid,
    output logic [FLIT_W-1:0]          out_flit,
    input  logic                       out_grant,
    output logic                       redirect_req,
    output logic                       ovf_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int SC_W = $clog2(STARVE_TH + 1);

    logic [SC_W-1:0] starve_cnt;
    logic [SC_W-1:0] starve_nxt;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(STARVE_TH)) ? v : v + SC_W'(1);
    endfunction

    minbd_sidebuf_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (buf_in_valid),
        .in_flit  (buf_in_flit),
        .grant    (out_grant),
        .full     (buf_full),
        .valid    (out_valid),
        .flit     (out_flit),
        .count    (count)
    );

    // A cycle is starved only when a flit is waiting and the re-inject mux declines it.
    assign starve_nxt = (out_valid & ~out_grant) ? sat_inc(starve_cnt) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt   <= '0;
            redirect_req <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            starve_cnt   <= starve_nxt;
            redirect_req <= (starve_nxt == SC_W'(STARVE_TH));
            if (buf_in_valid & buf_full) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_minbd_side_buffer.sv
// Directed self-checking bench for minbd_side_buffer (DEPTH=4, STARVE_TH=8).
module tb_minbd_side_buffer;

    localparam int FLIT_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              buf_in_valid;
    logic [FLIT_W-1:0] buf_in_flit;
    logic              buf_full;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              out_grant;
    logic              redirect_req;
    logic              ovf_err;
    logic [2:0]        count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    minbd_side_buffer #(.FLIT_W(FLIT_W), .DEPTH(4), .STARVE_TH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .buf_in_valid (buf_in_valid),
        .buf_in_flit  (buf_in_flit),
        .buf_full     (buf_full),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_grant    (out_grant),
        .redirect_req (redirect_req),
        .ovf_err      (ovf_err),
        .count        (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; buf_in_valid = 1'b1; buf_in_flit = 64'hEE; out_grant = 1'b0;
        tick(); tick();
        reset = 1'b1; buf_in_valid = 1'b0;
        checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
        checks++; if (buf_full !== 1'b0) $display("FAIL reset_buf_full: got %b want 0", buf_full); else passes++;
        checks++; if (redirect_req !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect_req); else passes++;
        checks++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf_err: got %b want 0", ovf_err); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_no_capture: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_order_fill();
        logic [FLIT_W-1:0] exp_vals [4] = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        for (int i = 0; i < 4; i++) begin
            buf_in_valid = 1'b1; buf_in_flit = exp_vals[i];
            tick();
        end
        buf_in_valid = 1'b0;
        checks++; if (buf_full !== 1'b1) $display("FAIL fill_full: got %b want 1", buf_full); else passes++;
        checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else passes++;
        out_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_flit !== exp_vals[i]) $display("FAIL order_flit%0d: got %0h want %0h", i, out_flit, exp_vals[i]);
            else passes++;
            tick();
        end
        out_grant = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL order_drained: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_wrap_simultaneous();
        logic [FLIT_W-1:0] exp_q [$];
        logic [FLIT_W-1:0] want;
        exp_q = '{64'h01, 64'h02, 64'h10, 64'h11, 64'h12, 64'h13, 64'h14,
                  64'h15, 64'h16, 64'h17, 64'h18, 64'h19};
        for (int i = 0; i < 2; i++) begin
            buf_in_valid = 1'b1; buf_in_flit = 64'(i + 1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            buf_in_valid = 1'b1; buf_in_flit = 64'(16 + i); out_grant = 1'b1;
            want = exp_q.pop_front();
            checks++;
            if (out_flit !== want) $display("FAIL wrap_flit%0d: got %0h want %0h", i, out_flit, want);
            else passes++;
            tick();
            checks++;
            if (count !== 3'd2) $display("FAIL wrap_count%0d: got %0d want 2", i, count);
            else passes++;
        end
        buf_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            want = exp_q.pop_front();
            checks++;
            if (out_flit !== want) $display("FAIL wrap_tail%0d: got %0h want %0h", i, out_flit, want);
            else passes++;
            tick();
        end
        out_grant = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL wrap_drained: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_overflow();
        logic [FLIT_W-1:0] tail [3] = '{64'hB2, 64'hB3, 64'hB4};
        for (int i = 0; i < 4; i++) begin
            buf_in_valid = 1'b1; buf_in_flit = 64'hB1 + 64'(i);
            tick();
        end
        checks++; if (buf_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", buf_full); else passes++;
        buf_in_flit = 64'hBF; out_grant = 1'b1;
        tick();
        buf_in_valid = 1'b0; out_grant = 1'b0;
        checks++; if (count !== 3'd3) $display("FAIL ovf_count: got %0d want 3", count); else passes++;
        checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", ovf_err); else passes++;
        repeat (5) tick();
        checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", ovf_err); else passes++;
        out_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_flit !== tail[i]) $display("FAIL ovf_tail%0d: got %0h want %0h", i, out_flit, tail[i]);
            else passes++;
            tick();
        end
        out_grant = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_starvation();
        buf_in_valid = 1'b1; buf_in_flit = 64'hC1;
        tick();
        buf_in_valid = 1'b0;
        repeat (7) tick();
        checks++; if (redirect_req !== 1'b0) $display("FAIL starve_early: got %b want 0", redirect_req); else passes++;
        tick();
        checks++; if (redirect_req !== 1'b1) $display("FAIL starve_rise: got %b want 1", redirect_req); else passes++;
        repeat (3) tick();
        checks++; if (redirect_req !== 1'b1) $display("FAIL starve_hold: got %b want 1", redirect_req); else passes++;
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        checks++; if (redirect_req !== 1'b0) $display("FAIL starve_drop: got %b want 0", redirect_req); else passes++;
        // A fresh flit must need the full threshold again.
        buf_in_valid = 1'b1; buf_in_flit = 64'hC2;
        tick();
        buf_in_valid = 1'b0;
        repeat (7) tick();
        checks++; if (redirect_req !== 1'b0) $display("FAIL starve_restart_early: got %b want 0", redirect_req); else passes++;
        tick();
        checks++; if (redirect_req !== 1'b1) $display("FAIL starve_restart_rise: got %b want 1", redirect_req); else passes++;
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin
            buf_in_valid = 1'b1; buf_in_flit = 64'hD1 + 64'(i);
            tick();
        end
        buf_in_valid = 1'b0;
        repeat (8) tick();
        checks++; if (redirect_req !== 1'b1) $display("FAIL midop_pre_redirect: got %b want 1", redirect_req); else passes++;
        checks++; if (count !== 3'd3) $display("FAIL midop_pre_count: got %0d want 3", count); else passes++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (count !== 3'd0) $display("FAIL midop_count: got %0d want 0", count); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL midop_out_valid: got %b want 0", out_valid); else passes++;
        checks++; if (redirect_req !== 1'b0) $display("FAIL midop_redirect: got %b want 0", redirect_req); else passes++;
        checks++; if (ovf_err !== 1'b0) $display("FAIL midop_ovf_err: got %b want 0", ovf_err); else passes++;
        buf_in_valid = 1'b1; buf_in_flit = 64'h55;
        tick();
        buf_in_valid = 1'b0;
        checks++; if (out_flit !== 64'h55) $display("FAIL midop_flit: got %0h want 55", out_flit); else passes++;
        checks++; if (count !== 3'd1) $display("FAIL midop_single: got %0d want 1", count); else passes++;
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL midop_drained: got %b want 0", out_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_order_fill();
        test_wrap_simultaneous();
        test_overflow();
        test_starvation();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
